// File: rtl/fft16_sdf_ctrl.sv
// Sequencing controller for a 16-point radix-2 SDF FFT (stage delays 8/4/2/1).
// Drives frame counting, stage selects, twiddle indices, pad/drain and output framing.
module fft16_sdf_ctrl #(
   parameter int PIPE_LAT = 1,
   parameter int TW_W     = 3
) (
   input  logic            clk,
   input  logic            clear,
   input  logic            in_valid,
   input  logic            in_last,
   output logic            in_ready,
   output logic            pipe_en,
   output logic            zero_ins,
   output logic [3:0]      stage_sel,
   output logic [TW_W-1:0] tw_idx1,
   output logic [TW_W-1:0] tw_idx2,
   output logic [TW_W-1:0] tw_idx3,
   output logic            out_valid,
   output logic            out_sop,
   output logic [3:0]      out_idx,
   output logic            busy
);
   localparam int L  = 15 + 4 * PIPE_LAT;
   localparam int DW = $clog2(L);
   localparam logic [DW-1:0] DLAST = DW'(L - 1);
   // Only the low bits of each stage counter are ever decoded, so the
   // offsets are kept modulo the width actually needed.
   localparam logic [2:0] D2 = 3'((8 + PIPE_LAT) % 8);
   localparam logic [1:0] D3 = 2'((12 + 2 * PIPE_LAT) % 4);
   localparam logic       D4 = 1'((14 + 3 * PIPE_LAT) % 2);

   typedef enum logic [1:0] {IDLE, RUN, PAD, DRAIN} state_t;

   state_t          state, state_nx;
   logic [3:0]      cnt, cnt_nx;
   logic [DW-1:0]   dcnt, dcnt_nx;
   logic [L-1:0]    tok;
   logic [3:0]      ocnt;
   logic [3:0]      c1;
   logic [2:0]      c2;
   logic [1:0]      c3;
   logic            c4;

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      dcnt_nx  = dcnt;
      in_ready = 1'b0;
      pipe_en  = 1'b0;
      case (state)
         IDLE, RUN: begin
            in_ready = clear;
            pipe_en  = clear & in_valid;
            if (in_valid) begin
               cnt_nx = cnt + 4'd1;
               if (in_last)
                  state_nx = (cnt == 4'd15) ? DRAIN : PAD;
               else
                  state_nx = RUN;
            end
         end
         PAD: begin
            pipe_en = clear;
            cnt_nx  = cnt + 4'd1;
            if (cnt == 4'd15)
               state_nx = DRAIN;
         end
         DRAIN: begin
            pipe_en = clear;
            cnt_nx  = cnt + 4'd1;
            dcnt_nx = dcnt + DW'(1);
            // Frame counter restarts at 0 so the next frame aligns with stage 1.
            if (dcnt == DLAST) begin
               state_nx = IDLE;
               cnt_nx   = 4'd0;
               dcnt_nx  = '0;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         state <= IDLE;
         cnt   <= 4'd0;
         dcnt  <= '0;
         tok   <= '0;
         ocnt  <= 4'd0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         dcnt  <= dcnt_nx;
         if (pipe_en)
            tok <= {tok[L-2:0], (state != DRAIN)};
         if (out_valid)
            ocnt <= ocnt + 4'd1;
      end
   end

   assign c1 = cnt;
   assign c2 = cnt[2:0] - D2;
   assign c3 = cnt[1:0] - D3;
   assign c4 = cnt[0] ^ D4;

   assign busy      = (state != IDLE);
   assign zero_ins  = (state == PAD) || (state == DRAIN);
   assign stage_sel = busy ? {c4, c3[1], c2[2], c1[3]} : 4'b0000;
   assign tw_idx1   = stage_sel[0] ? TW_W'(c1[2:0]) : '0;
   assign tw_idx2   = stage_sel[1] ? TW_W'({c2[1:0], 1'b0}) : '0;
   assign tw_idx3   = stage_sel[2] ? TW_W'({c3[0], 2'b00}) : '0;

   assign out_valid = tok[L-1] & pipe_en;
   assign out_sop   = out_valid & (ocnt == 4'd0);
   assign out_idx   = {ocnt[0], ocnt[1], ocnt[2], ocnt[3]};
endmodule

// File: tb/tb_fft16_sdf_ctrl.sv
// Bench for fft16_sdf_ctrl: directed and random frames checked against a
// pipe-cycle based reference model with an expected output-index queue.
module tb_fft16_sdf_ctrl;
   localparam int PL = 1;
   localparam int TW = 3;
   localparam int L  = 15 + 4 * PL;
   localparam int D2 = 8 + PL;
   localparam int D3 = 12 + 2 * PL;
   localparam int D4 = 14 + 3 * PL;

   logic          clk = 1'b0;
   logic          clear = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_last = 1'b0;
   logic          in_ready, pipe_en, zero_ins;
   logic [3:0]    stage_sel;
   logic [TW-1:0] tw_idx1, tw_idx2, tw_idx3;
   logic          out_valid, out_sop, busy;
   logic [3:0]    out_idx;

   int checks = 0;
   int errors = 0;
   int p, pend, tok_cnt, ov_seen, sop_seen;
   bit busy_m, last_m;
   logic [3:0] exp_q[$];

   fft16_sdf_ctrl #(.PIPE_LAT(PL), .TW_W(TW)) dut (
      .clk(clk), .clear(clear), .in_valid(in_valid), .in_last(in_last),
      .in_ready(in_ready), .pipe_en(pipe_en), .zero_ins(zero_ins),
      .stage_sel(stage_sel), .tw_idx1(tw_idx1), .tw_idx2(tw_idx2),
      .tw_idx3(tw_idx3), .out_valid(out_valid), .out_sop(out_sop),
      .out_idx(out_idx), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic int mod16(input int x);
      return ((x % 16) + 16) % 16;
   endfunction

   function automatic int bitrev4(input int x);
      int r = 0;
      for (int b = 0; b < 4; b++)
         if ((x >> b) % 2 == 1) r += 1 << (3 - b);
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      p = 0; pend = 0; tok_cnt = 0;
      busy_m = 0; last_m = 0;
      exp_q.delete();
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_in_ready"}, in_ready, 0);
      chk({tag, "_pipe_en"}, pipe_en, 0);
      chk({tag, "_zero_ins"}, zero_ins, 0);
      chk({tag, "_stage_sel"}, stage_sel, 0);
      chk({tag, "_tw1"}, tw_idx1, 0);
      chk({tag, "_tw2"}, tw_idx2, 0);
      chk({tag, "_tw3"}, tw_idx3, 0);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_out_sop"}, out_sop, 0);
      chk({tag, "_out_idx"}, out_idx, 0);
      chk({tag, "_busy"}, busy, 0);
   endtask

   // One clock: drive, check at negedge, advance model at posedge.
   task automatic cycle(input logic v, input logic last);
      logic rdy_e, pen_e, zi_e, ov_e;
      logic [3:0] sel_e;
      int c1, c2, c3, c4, tw1_e, tw2_e, tw3_e;
      logic [3:0] idx_e;
      in_valid = v;
      in_last  = last;
      @(negedge clk);
      if (!last_m) begin
         rdy_e = 1; pen_e = v; zi_e = 0;
      end else begin
         rdy_e = 0; pen_e = 1; zi_e = 0;
         zi_e = 1;
      end
      ov_e = pen_e && (p >= L) && (!last_m || (p - L) < pend);
      c1 = mod16(p); c2 = mod16(p - D2); c3 = mod16(p - D3); c4 = mod16(p - D4);
      sel_e = 4'b0000;
      if (busy_m) begin
         sel_e[0] = (c1 >= 8);
         sel_e[1] = (c2 % 8 >= 4);
         sel_e[2] = (c3 % 4 >= 2);
         sel_e[3] = (c4 % 2 >= 1);
      end
      tw1_e = sel_e[0] ? c1 % 8 : 0;
      tw2_e = sel_e[1] ? (c2 % 4) * 2 : 0;
      tw3_e = sel_e[2] ? (c3 % 2) * 4 : 0;
      chk("in_ready", in_ready, rdy_e);
      chk("pipe_en", pipe_en, pen_e);
      chk("zero_ins", zero_ins, zi_e);
      chk("busy", busy, busy_m);
      chk("stage_sel", stage_sel, sel_e);
      chk("tw_idx1", tw_idx1, tw1_e);
      chk("tw_idx2", tw_idx2, tw2_e);
      chk("tw_idx3", tw_idx3, tw3_e);
      chk("out_valid", out_valid, ov_e);
      if (ov_e) begin
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $error("FAIL idx_queue observed=empty expected=entry p=%0d", p);
         end else begin
            idx_e = exp_q.pop_front();
            chk("out_idx", out_idx, idx_e);
            chk("out_sop", out_sop, idx_e == 4'd0);
         end
      end else begin
         chk("out_sop_idle", out_sop, 0);
      end
      ov_seen  += int'(out_valid);
      sop_seen += int'(out_sop);
      @(posedge clk);
      if (pen_e) begin
         if (!last_m || p < pend) begin
            exp_q.push_back(4'(bitrev4(tok_cnt % 16)));
            tok_cnt++;
         end
         if (!last_m && v) begin
            busy_m = 1;
            if (last) begin
               last_m = 1;
               pend   = (p / 16 + 1) * 16;
            end
         end
         p++;
         if (last_m && p == pend + L) begin
            busy_m = 0; last_m = 0; p = 0;
         end
      end
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0);
   endtask

   initial begin
      int len, acc;
      logic v;
      model_reset();
      clear = 0; in_valid = 1; in_last = 0;
      #12;
      reset_checks("rst");
      in_valid = 0;
      @(posedge clk); #1;
      clear = 1;

      // Single full frame
      ov_seen = 0; sop_seen = 0;
      for (int i = 0; i < 16; i++) cycle(1, i == 15);
      idle(40);
      chk("full_ov_count", ov_seen, 16);
      chk("full_sop_count", sop_seen, 1);

      // Three-cycle stall mid-frame
      ov_seen = 0; sop_seen = 0;
      for (int i = 0; i < 16; i++) begin
         if (i == 7) idle(3);
         cycle(1, i == 15);
      end
      idle(40);
      chk("stall_ov_count", ov_seen, 16);
      chk("stall_sop_count", sop_seen, 1);

      // Short frame: last at cnt=4, input noise ignored during pad/drain
      ov_seen = 0; sop_seen = 0;
      for (int i = 0; i < 5; i++) cycle(1, i == 4);
      for (int i = 0; i < 30; i++) cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      idle(5);
      chk("pad_ov_count", ov_seen, 16);
      chk("pad_sop_count", sop_seen, 1);

      // Two frames back to back
      ov_seen = 0; sop_seen = 0;
      for (int i = 0; i < 32; i++) cycle(1, i == 31);
      idle(40);
      chk("b2b_ov_count", ov_seen, 32);
      chk("b2b_sop_count", sop_seen, 2);

      // Random lengths with random source gaps
      for (int f = 0; f < 6; f++) begin
         ov_seen = 0; sop_seen = 0;
         len = $urandom_range(1, 40);
         acc = 0;
         while (acc < len) begin
            v = ($urandom_range(0, 3) != 0);
            cycle(v, acc == len - 1);
            if (v) acc++;
         end
         idle(60);
         chk("rand_ov_count", ov_seen, ((len + 15) / 16) * 16);
         chk("rand_sop_count", sop_seen, (len + 15) / 16);
      end

      // Clear during drain, then a clean frame
      for (int i = 0; i < 16; i++) cycle(1, i == 15);
      idle(8);
      in_valid = 0; in_last = 0;
      clear = 0;
      #1;
      reset_checks("clr");
      @(posedge clk); #1;
      clear = 1;
      model_reset();
      ov_seen = 0; sop_seen = 0;
      for (int i = 0; i < 16; i++) cycle(1, i == 15);
      idle(40);
      chk("post_clr_ov_count", ov_seen, 16);
      chk("post_clr_sop_count", sop_seen, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
